// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed hex driver for a bank of common-segment
// 7-segment digits. Scans one digit per CLK_DIV-cycle slot, opens each slot
// with a BLANK_CYC-cycle all-off gap to stop ghosting, and swaps in newly
// loaded data only at a frame boundary so a frame never shows mixed values.
//
// Optional feature: define SEG7_SCAN_DP_EN to add per-digit decimal points
// (dp_in latched with load, dp output).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              1-cycle strobe capturing value/blank_mask into pending
//   value[4*DIGITS]   packed nibbles, nibble k -> digit k (digit 0 = LS)
//   blank_mask[DIGITS] 1 = digit k forced dark
//   lz_en             live leading-zero suppression enable
//   disp[7]           segments a..g on [0]..[6], active-high, registered
//   an[DIGITS]        one-hot digit enable, active-high, registered
//   upd               1-cycle pulse when pending data becomes displayed
//   dp_in, dp         (SEG7_SCAN_DP_EN only) decimal point in/out

// Per-digit decode: hex nibble to segments, forced dark on request.
module seg7_scan_lane (
  input  logic [3:0] nib_i,
  input  logic       dark_i,
  output logic [6:0] seg_o
);
  logic [6:0] dec;

  always_comb begin
    dec = 7'h00;
    case (nib_i)
      4'h0: dec = 7'h3F;  4'h1: dec = 7'h06;
      4'h2: dec = 7'h5B;  4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;  4'h5: dec = 7'h6D;
      4'h6: dec = 7'h7D;  4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;  4'h9: dec = 7'h6F;
      4'hA: dec = 7'h77;  4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;  4'hD: dec = 7'h5E;
      4'hE: dec = 7'h79;  4'hF: dec = 7'h71;
      default: dec = 7'h00;
    endcase
    seg_o = dark_i ? 7'h00 : dec;
  end
endmodule

module seg7_scan #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
`ifdef SEG7_SCAN_DP_EN
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  dp,
`endif
  output logic [6:0]            disp,
  output logic [DIGITS-1:0]     an,
  output logic                  upd
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1)           begin : g_bad_digits $error("seg7_scan: DIGITS must be >= 1"); end
  if (CLK_DIV < 2)          begin : g_bad_div    $error("seg7_scan: CLK_DIV must be >= 2"); end
  if (BLANK_CYC >= CLK_DIV) begin : g_bad_blank  $error("seg7_scan: BLANK_CYC must be < CLK_DIV"); end

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d, shown_val_q, shown_val_d;
  logic [DIGITS-1:0]     pend_mask_q, pend_mask_d, shown_mask_q, shown_mask_d;
  logic [6:0]            disp_q, disp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  upd_q, upd_d;
  logic                  tick, frame_end, xfer, in_gap;
  logic [DIGITS-1:0]     lz_dark;
  logic                  zero_run;
  logic [DIGITS-1:0][6:0] lane_seg;

  assign tick      = (presc_q == PW'(CLK_DIV - 1));
  assign frame_end = tick && (idx_q == IW'(DIGITS - 1));
  assign xfer      = frame_end && pending_q;
  assign in_gap    = (presc_q < PW'(BLANK_CYC));

  // lz_dark[k]: every shown nibble from the top down to k is zero.
  // Digit 0 is left out so a zero value still shows a single "0".
  always_comb begin
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (shown_val_q[4*k +: 4] == 4'h0);
      lz_dark[k] = zero_run;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    seg7_scan_lane u_lane (
      .nib_i  (shown_val_q[4*k +: 4]),
      .dark_i (shown_mask_q[k] | (lz_en & lz_dark[k])),
      .seg_o  (lane_seg[k])
    );
  end

  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    pending_d    = pending_q;
    pend_val_d   = pend_val_q;
    pend_mask_d  = pend_mask_q;
    shown_val_d  = shown_val_q;
    shown_mask_d = shown_mask_q;
    // Transfer uses the old pending contents; a simultaneous load wins the
    // pending flag so it is shown one frame later.
    if (xfer) begin
      shown_val_d  = pend_val_q;
      shown_mask_d = pend_mask_q;
      pending_d    = 1'b0;
    end
    if (load) begin
      pend_val_d  = value;
      pend_mask_d = blank_mask;
      pending_d   = 1'b1;
    end
    upd_d  = xfer;
    an_d   = in_gap ? '0 : (DIGITS'(1) << idx_q);
    disp_d = in_gap ? 7'h00 : lane_seg[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      pend_val_q   <= '0;
      pend_mask_q  <= '0;
      shown_val_q  <= '0;
      shown_mask_q <= '1;
      disp_q       <= 7'h00;
      an_q         <= '0;
      upd_q        <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_val_q   <= pend_val_d;
      pend_mask_q  <= pend_mask_d;
      shown_val_q  <= shown_val_d;
      shown_mask_q <= shown_mask_d;
      disp_q       <= disp_d;
      an_q         <= an_d;
      upd_q        <= upd_d;
    end
  end

  assign disp = disp_q;
  assign an   = an_q;
  assign upd  = upd_q;

`ifdef SEG7_SCAN_DP_EN
  logic [DIGITS-1:0] pend_dp_q, shown_dp_q;
  logic              dp_q;

  // Blank mask also kills the point; leading-zero suppression does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dp_q  <= '0;
      shown_dp_q <= '0;
      dp_q       <= 1'b0;
    end else begin
      if (xfer) shown_dp_q <= pend_dp_q;
      if (load) pend_dp_q  <= dp_in;
      dp_q <= !in_gap && shown_dp_q[idx_q] && !shown_mask_q[idx_q];
    end
  end

  assign dp = dp_q;
`endif
endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed driver for a bank of common-segment 7-segment digits; successor to the single-digit combinational seg7 decoder.
- Decodes a packed hex value (0-F, not just 0-9) and scans one digit per refresh slot.
- Adds per-digit blanking, leading-zero suppression, a tear-free frame-boundary update, and an inter-digit ghost-blanking gap.
- Sits between the datapath value register and the board's segment and anode pins.

Parameters:
- DIGITS, 4: number of digits scanned; must be >= 1.
- CLK_DIV, 50000: clk cycles per digit slot; must be >= 2.
- BLANK_CYC, 2: cycles at the start of each slot with all outputs off; must be < CLK_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  single-cycle strobe; captures value/blank_mask into the pending registers
- value  input  4*DIGITS  packed nibbles; nibble k drives digit k; digit 0 is least significant
- blank_mask  input  DIGITS  1 = force digit k dark
- lz_en  input  1  1 = suppress leading zeros; sampled live, not latched
- disp  output  7  segments, active-high; [0]=a top, [1]=b upper-right, [2]=c lower-right, [3]=d bottom, [4]=e lower-left, [5]=f upper-left, [6]=g middle
- an  output  DIGITS  one-hot digit enable, active-high
- upd  output  1  one-cycle pulse when pending data becomes displayed

Behaviour:
- Reset (async, rst_n=0):
  - prescaler=0, idx=0, pending=0.
  - shown value=0, shown mask=all 1s, so the display starts dark.
  - disp=0, an=0, upd=0.
- Prescaler: counts 0..CLK_DIV-1, then wraps. tick = (prescaler==CLK_DIV-1).
- Digit index: on tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Frame boundary: a tick with idx==DIGITS-1. When DIGITS=1, every tick is a frame boundary.
- Load path:
  - load=1 writes pend_val/pend_mask and sets pending=1.
  - A second load before transfer overwrites the pending data (last wins).
- Transfer: on a frame boundary with pending=1:
  - shown <= pend, pending <= 0, upd=1 for that same cycle (registered).
  - Mid-frame loads never change the displayed digits.
- Load and frame boundary in the same cycle:
  - The transfer uses the old pend contents.
  - The new load lands in pend, and pending stays 1.
- Decode (hex to disp):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Digit k is dark (disp=0 while it is selected) if:
  - shown_mask[k]=1, or
  - lz_en=1 and k>0 and every shown nibble from DIGITS-1 down to k is 0.
  - Digit 0 is never suppressed by lz_en.
- Outputs are registered and reflect prescaler/idx state with one cycle of latency:
  - If prescaler < BLANK_CYC: an=0, disp=0.
  - Otherwise: an = 1<<idx, and disp = decoded (or dark) segments of digit idx.
  - A digit that is dark still has its an bit asserted; only disp goes to 0.
- Reset mid-scan: all state clears immediately; pending data is lost; no upd pulse.
- Implementation checks: illegal parameters (DIGITS<1, CLK_DIV<2, BLANK_CYC>=CLK_DIV) are rejected with an elaboration-time $error.

Optional Feature:
- Macro: SEG7_SCAN_DP_EN.
- Defined:
  - Adds input dp_in[DIGITS-1:0] and output dp.
  - dp_in is latched with load and transferred at the frame boundary like value.
  - dp = shown_dp[idx] outside the blank gap, 0 inside it.
  - blank_mask forces dp=0; lz_en does not affect dp.
  - dp resets to 0.
- Undefined: ports dp_in and dp do not exist, and no DP registers are built.

Test Plan:
All scenarios use DIGITS=4, CLK_DIV=4, BLANK_CYC=1 unless stated.
1. Reset then load value=16'h12AF, mask=0 -> after first frame boundary, upd pulses once; slots show an=0001/disp=71, 0010/77, 0100/5B, 1000/06. an=0 for 1 cycle at each slot start.
2. Sweep each nibble 0..F on digit 0 -> disp matches the decode table exactly, including 9=6F.
3. lz_en=1, value=16'h0070 -> digit3 and digit2 have disp=0; digit1=07, digit0=3F. value=16'h0000 -> only digit0 lit (3F).
4. Loads at mid-frame: 16'h1111, then 16'h2222 two cycles later -> displayed digits stay on the old value until the boundary, then show 2; exactly one upd pulse.
5. load asserted exactly on the frame-boundary cycle -> the old pend value is displayed; the new value appears one frame later with a second upd pulse.
6. rst_n low mid-slot -> disp, an and upd are 0 asynchronously; after release, idx restarts at digit0 and the display stays dark until the next load. With SEG7_SCAN_DP_EN defined, dp_in=4'b0100 -> dp=1 only while an=0100 and outside the blank gap.
